mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arm_pkg.sv | 15 +
 rtl/starve_counter.sv | 24 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package arm_pkg;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;
  localparam int unsigned DATA_W             = 32;
  localparam int unsigned ADDR_W             = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of data grants made while an instruction fetch waits.
module starve_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count
);

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CW'(MAX))) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-outstanding memory bus.
module mem_arbiter
  import arm_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  arb_state_t  state;
  arb_state_t  state_nx;
  logic [CW-1:0] starve_cnt;
  logic        grant_i;
  logic        grant_d;
  logic        starved;

  logic        m_en_nx;
  logic        m_we_nx;
  logic [31:0] m_addr_nx;
  logic [31:0] m_wdata_nx;
  logic        i_ready_nx;
  logic        d_ready_nx;
  logic [31:0] i_rdata_nx;
  logic [31:0] d_rdata_nx;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // Starvation bookkeeping: count data wins over a waiting fetch, clear on fetch win.
  starve_counter #(
    .MAX (STARVE_MAX),
    .CW  (CW)
  ) u_starve_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d & i_req),
    .clr   (grant_i),
    .count (starve_cnt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, grant decision and next values for the registered outputs.
  always_comb begin
    state_nx   = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    m_en_nx    = m_en;
    m_we_nx    = m_we;
    m_addr_nx  = m_addr;
    m_wdata_nx = m_wdata;
    i_ready_nx = 1'b0;
    d_ready_nx = 1'b0;
    i_rdata_nx = i_rdata;
    d_rdata_nx = d_rdata;

    case (state)
      IDLE: begin
        if (d_req && !(i_req && starved)) begin
          grant_d    = 1'b1;
          m_en_nx    = 1'b1;
          m_we_nx    = d_we;
          m_addr_nx  = d_addr;
          m_wdata_nx = d_wdata;
          state_nx   = DBUSY;
        end else if (i_req) begin
          grant_i    = 1'b1;
          m_en_nx    = 1'b1;
          m_we_nx    = 1'b0;
          m_addr_nx  = i_addr;
          m_wdata_nx = 32'h0;
          state_nx   = IBUSY;
        end
      end
      IBUSY: begin
        if (m_ack) begin
          i_rdata_nx = m_rdata;
          i_ready_nx = 1'b1;
          m_en_nx    = 1'b0;
          state_nx   = DONE;
        end
      end
      DBUSY: begin
        if (m_ack) begin
          if (!m_we) begin
            d_rdata_nx = m_rdata;
          end
          d_ready_nx = 1'b1;
          m_en_nx    = 1'b0;
          state_nx   = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        m_en_nx  = 1'b0;
      end
    endcase
  end

  // Output registers; reset also aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= 32'h0;
      m_wdata <= 32'h0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= 32'h0;
      d_rdata <= 32'h0;
    end else begin
      m_en    <= m_en_nx;
      m_we    <= m_we_nx;
      m_addr  <= m_addr_nx;
      m_wdata <= m_wdata_nx;
      i_ready <= i_ready_nx;
      d_ready <= d_ready_nx;
      i_rdata <= i_rdata_nx;
      d_rdata <= d_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  import arm_pkg::*;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    m_rdata = 32'h0;
    m_ack   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_m_en",    32'(m_en),    32'h0);
    chk("rst_m_we",    32'(m_we),    32'h0);
    chk("rst_m_addr",  m_addr,       32'h0);
    chk("rst_m_wdata", m_wdata,      32'h0);
    chk("rst_i_ready", 32'(i_ready), 32'h0);
    chk("rst_d_ready", 32'(d_ready), 32'h0);
    chk("rst_i_rdata", i_rdata,      32'h0);
    chk("rst_d_rdata", d_rdata,      32'h0);
    chk("rst_state",   32'(dut.state), 32'(IDLE));
    chk("rst_starve",  32'(dut.starve_cnt), 32'h0);
    reset = 1'b0;
    tick();

    // Single fetch, ack in first busy cycle
    i_req  = 1'b1;
    i_addr = 32'h0000_0010;
    tick();
    chk("f1_state",   32'(dut.state), 32'(IBUSY));
    chk("f1_m_en",    32'(m_en),    32'h1);
    chk("f1_m_we",    32'(m_we),    32'h0);
    chk("f1_m_addr",  m_addr,       32'h0000_0010);
    chk("f1_i_ready", 32'(i_ready), 32'h0);
    m_ack   = 1'b1;
    m_rdata = 32'hE3A0_1005;
    tick();
    chk("f1_done_ready", 32'(i_ready), 32'h1);
    chk("f1_done_rdata", i_rdata,      32'hE3A0_1005);
    chk("f1_done_m_en",  32'(m_en),    32'h0);
    m_ack = 1'b0;
    i_req = 1'b0;
    tick();
    chk("f1_idle_ready", 32'(i_ready), 32'h0);
    chk("f1_idle_hold",  i_rdata,      32'hE3A0_1005);
    chk("f1_idle_state", 32'(dut.state), 32'(IDLE));

    // Simultaneous store and fetch: data wins first
    i_req   = 1'b1;
    i_addr  = 32'h0000_0020;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0080;
    d_wdata = 32'h0000_0007;
    tick();
    chk("st_state",   32'(dut.state), 32'(DBUSY));
    chk("st_m_en",    32'(m_en),    32'h1);
    chk("st_m_we",    32'(m_we),    32'h1);
    chk("st_m_addr",  m_addr,       32'h0000_0080);
    chk("st_m_wdata", m_wdata,      32'h0000_0007);
    chk("st_starve",  32'(dut.starve_cnt), 32'h1);
    m_ack   = 1'b1;
    m_rdata = 32'hDEAD_BEEF;
    tick();
    chk("st_d_ready", 32'(d_ready), 32'h1);
    chk("st_i_ready", 32'(i_ready), 32'h0);
    chk("st_d_rdata", d_rdata,      32'h0);
    m_ack = 1'b0;
    d_req = 1'b0;
    tick();
    chk("st_idle_d_ready", 32'(d_ready), 32'h0);
    tick();
    chk("sf_state",   32'(dut.state), 32'(IBUSY));
    chk("sf_m_addr",  m_addr,       32'h0000_0020);
    chk("sf_m_we",    32'(m_we),    32'h0);
    chk("sf_starve",  32'(dut.starve_cnt), 32'h0);
    m_ack   = 1'b1;
    m_rdata = 32'h1111_2222;
    tick();
    chk("sf_i_ready", 32'(i_ready), 32'h1);
    chk("sf_i_rdata", i_rdata,      32'h1111_2222);
    m_ack = 1'b0;
    i_req = 1'b0;
    tick();

    // Starvation: four data grants, then the fetch wins
    i_req  = 1'b1;
    i_addr = 32'h0000_0040;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 4) begin
        chk("sv_grant_d", 32'(dut.state), 32'(DBUSY));
        chk("sv_cnt_d",   32'(dut.starve_cnt), 32'(k + 1));
      end else begin
        chk("sv_grant_i", 32'(dut.state), 32'(IBUSY));
        chk("sv_cnt_i",   32'(dut.starve_cnt), 32'h0);
      end
      m_ack   = 1'b1;
      m_rdata = 32'h0000_00A0 + 32'(k);
      tick();
      if (k < 4) begin
        chk("sv_d_ready", 32'(d_ready), 32'h1);
        chk("sv_d_rdata", d_rdata,      32'h0000_00A0 + 32'(k));
      end else begin
        chk("sv_i_ready", 32'(i_ready), 32'h1);
        chk("sv_i_rdata", i_rdata,      32'h0000_00A4);
        i_req = 1'b0;
        d_req = 1'b0;
      end
      m_ack = 1'b0;
      tick();
    end
    chk("sv_cnt_after", 32'(dut.starve_cnt), 32'h0);

    // Memory stall of 5 cycles, then ack; stray ack in IDLE
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0200;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("stall_m_addr",  m_addr,       32'h0000_0200);
      chk("stall_m_en",    32'(m_en),    32'h1);
      chk("stall_d_ready", 32'(d_ready), 32'h0);
      d_addr = 32'h0000_0FFF;
      tick();
    end
    chk("stall_m_addr_last", m_addr, 32'h0000_0200);
    m_ack   = 1'b1;
    m_rdata = 32'h55AA_55AA;
    tick();
    chk("stall_d_ready_pulse", 32'(d_ready), 32'h1);
    chk("stall_d_rdata",       d_rdata,      32'h55AA_55AA);
    m_ack = 1'b0;
    d_req = 1'b0;
    tick();
    chk("stall_idle_d_ready", 32'(d_ready), 32'h0);
    m_ack = 1'b1;
    tick();
    chk("stray_state",   32'(dut.state), 32'(IDLE));
    chk("stray_m_en",    32'(m_en),    32'h0);
    chk("stray_d_ready", 32'(d_ready), 32'h0);
    chk("stray_i_ready", 32'(i_ready), 32'h0);
    m_ack = 1'b0;
    tick();
    chk("stray_after_d_ready", 32'(d_ready), 32'h0);

    // Reset during DBUSY with a late ack
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h0000_0300;
    d_wdata = 32'h0000_0099;
    tick();
    chk("ab_state", 32'(dut.state), 32'(DBUSY));
    reset = 1'b1;
    tick();
    chk("ab_m_en",    32'(m_en),    32'h0);
    chk("ab_d_ready", 32'(d_ready), 32'h0);
    chk("ab_state_i", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    d_req = 1'b0;
    m_ack = 1'b1;
    tick();
    chk("ab_late_m_en",    32'(m_en),    32'h0);
    chk("ab_late_d_ready", 32'(d_ready), 32'h0);
    chk("ab_late_state",   32'(dut.state), 32'(IDLE));
    chk("ab_i_rdata_rst",  i_rdata,      32'h0);
    m_ack  = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h0000_0400;
    tick();
    chk("pf_state",  32'(dut.state), 32'(IBUSY));
    chk("pf_m_addr", m_addr,       32'h0000_0400);
    m_ack   = 1'b1;
    m_rdata = 32'hCAFE_0001;
    tick();
    chk("pf_i_ready", 32'(i_ready), 32'h1);
    chk("pf_i_rdata", i_rdata,      32'hCAFE_0001);
    m_ack = 1'b0;
    i_req = 1'b0;
    tick();
    chk("pf_idle_i_ready", 32'(i_ready), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
